// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: merges the core's instruction and data request ports onto
// one shared memory bus. Accepted requests push an owner tag into an in-order
// FIFO; each bus response is steered back to the owner at the FIFO head.
// Handshake: a request transfers in a cycle where req and gnt are both high;
// a response transfers in a cycle where recv and ack are both high. A stalled
// request keeps the bus (lock) until it is granted.
// Optional feature: define FRV_MEM_ARB_RR_EN for round-robin arbitration;
// otherwise dmem has fixed priority over imem.
module frv_mem_arbiter #(
   parameter int OUTSTANDING = 2
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        imem_req,
   input  logic        imem_wen,
   input  logic [3:0]  imem_strb,
   input  logic [31:0] imem_wdata,
   input  logic [31:0] imem_addr,
   output logic        imem_gnt,
   output logic        imem_recv,
   input  logic        imem_ack,
   output logic        imem_error,
   output logic [31:0] imem_rdata,
   input  logic        dmem_req,
   input  logic        dmem_wen,
   input  logic [3:0]  dmem_strb,
   input  logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_addr,
   output logic        dmem_gnt,
   output logic        dmem_recv,
   input  logic        dmem_ack,
   output logic        dmem_error,
   output logic [31:0] dmem_rdata,
   output logic        mem_req,
   output logic        mem_wen,
   output logic [3:0]  mem_strb,
   output logic [31:0] mem_wdata,
   output logic [31:0] mem_addr,
   input  logic        mem_gnt,
   input  logic        mem_recv,
   output logic        mem_ack,
   input  logic        mem_error,
   input  logic [31:0] mem_rdata,
   output logic        err_spurious
);

   localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
   localparam int CW = $clog2(OUTSTANDING + 1);
   localparam logic [PW-1:0] PTR_LAST = PW'(OUTSTANDING - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(OUTSTANDING);

   // Owner tag encoding shared by the FIFO, selection and RR pointer.
   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   // Lock FSM: remembers which port owns a stalled (ungranted) request.
   typedef enum logic [1:0] {
      LK_NONE = 2'd0,
      LK_I    = 2'd1,
      LK_D    = 2'd2
   } lock_state_t;

   lock_state_t lock_q, lock_next;

   logic [OUTSTANDING-1:0] tag_q;
   logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]          count_q;
   logic                   spurious_q;

   logic sel;
   logic policy_sel;
   logic full, empty, head;
   logic push, pop;

`ifdef FRV_MEM_ARB_RR_EN
   // rr_q holds the port that wins the next contested cycle.
   logic rr_q;

   // Round-robin: on contention the port not granted last wins.
   always_comb begin
      policy_sel = OWN_I;
      if (imem_req && dmem_req) policy_sel = rr_q;
      else if (dmem_req)        policy_sel = OWN_D;
   end

   // Advance the round-robin pointer past whichever port was just granted.
   always_ff @(posedge g_clk) begin
      if (!g_resetn)  rr_q <= OWN_D;
      else if (push)  rr_q <= ~sel;
   end
`else
   // Fixed priority: dmem wins whenever it requests.
   always_comb begin
      policy_sel = dmem_req ? OWN_D : OWN_I;
   end
`endif

   // Port selection: a locked owner overrides the arbitration policy.
   always_comb begin
      sel = policy_sel;
      case (lock_q)
         LK_I:    sel = OWN_I;
         LK_D:    sel = OWN_D;
         default: sel = policy_sel;
      endcase
   end

   // Request path: zero-cycle mux of the selected port onto the bus.
   always_comb begin
      full     = (count_q == CNT_FULL);
      mem_req  = (imem_req | dmem_req) & ~full;
      mem_wen  = (sel == OWN_D) ? dmem_wen   : imem_wen;
      mem_strb = (sel == OWN_D) ? dmem_strb  : imem_strb;
      mem_wdata= (sel == OWN_D) ? dmem_wdata : imem_wdata;
      mem_addr = (sel == OWN_D) ? dmem_addr  : imem_addr;
      imem_gnt = mem_gnt & mem_req & (sel == OWN_I);
      dmem_gnt = mem_gnt & mem_req & (sel == OWN_D);
      push     = mem_req & mem_gnt;
   end

   // Response path: route to the FIFO head owner; empty FIFO drops responses.
   always_comb begin
      empty      = (count_q == '0);
      head       = tag_q[rd_ptr_q];
      imem_recv  = mem_recv & ~empty & (head == OWN_I);
      dmem_recv  = mem_recv & ~empty & (head == OWN_D);
      imem_rdata = imem_recv ? mem_rdata : '0;
      dmem_rdata = dmem_recv ? mem_rdata : '0;
      imem_error = imem_recv & mem_error;
      dmem_error = dmem_recv & mem_error;
      if (empty) mem_ack = mem_recv;
      else       mem_ack = (head == OWN_D) ? dmem_ack : imem_ack;
      pop        = mem_recv & mem_ack & ~empty;
   end

   // Lock next state: set on a stalled request, cleared once it is granted.
   always_comb begin
      lock_next = lock_q;
      if (mem_req && mem_gnt)  lock_next = LK_NONE;
      else if (mem_req)        lock_next = (sel == OWN_D) ? LK_D : LK_I;
   end

   // Lock state register.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) lock_q <= LK_NONE;
      else           lock_q <= lock_next;
   end

   // Tag FIFO storage, pointers and occupancy count.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         tag_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            tag_q[wr_ptr_q] <= sel;
            wr_ptr_q        <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
         end
         if (pop) begin
            rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
         end
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   // Sticky flag for a bus response arriving with nothing outstanding.
   always_ff @(posedge g_clk) begin
      if (!g_resetn)               spurious_q <= 1'b0;
      else if (mem_recv && empty)  spurious_q <= 1'b1;
   end

   assign err_spurious = spurious_q;

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// Directed bench for frv_mem_arbiter (OUTSTANDING=2). Inputs change just
// after the falling edge and outputs are checked 1ns later, well away from
// the rising edge that updates state.
module tb_frv_mem_arbiter;

   logic        g_clk = 1'b0;
   logic        g_resetn;
   logic        imem_req, imem_wen, imem_ack;
   logic [3:0]  imem_strb;
   logic [31:0] imem_wdata, imem_addr;
   logic        imem_gnt, imem_recv, imem_error;
   logic [31:0] imem_rdata;
   logic        dmem_req, dmem_wen, dmem_ack;
   logic [3:0]  dmem_strb;
   logic [31:0] dmem_wdata, dmem_addr;
   logic        dmem_gnt, dmem_recv, dmem_error;
   logic [31:0] dmem_rdata;
   logic        mem_req, mem_wen, mem_gnt, mem_recv, mem_ack, mem_error;
   logic [3:0]  mem_strb;
   logic [31:0] mem_wdata, mem_addr, mem_rdata;
   logic        err_spurious;

   int checks = 0;
   int errors = 0;
   logic [0:0] exp_q[$];

   // clock / reset
   always #5 g_clk = ~g_clk;

   frv_mem_arbiter #(.OUTSTANDING(2)) dut (
      .g_clk(g_clk), .g_resetn(g_resetn),
      .imem_req(imem_req), .imem_wen(imem_wen), .imem_strb(imem_strb),
      .imem_wdata(imem_wdata), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_recv(imem_recv), .imem_ack(imem_ack), .imem_error(imem_error),
      .imem_rdata(imem_rdata),
      .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
      .dmem_wdata(dmem_wdata), .dmem_addr(dmem_addr), .dmem_gnt(dmem_gnt),
      .dmem_recv(dmem_recv), .dmem_ack(dmem_ack), .dmem_error(dmem_error),
      .dmem_rdata(dmem_rdata),
      .mem_req(mem_req), .mem_wen(mem_wen), .mem_strb(mem_strb),
      .mem_wdata(mem_wdata), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error),
      .mem_rdata(mem_rdata), .err_spurious(err_spurious)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // driver tasks
   task automatic clear_inputs();
      imem_req = 0; imem_wen = 0; imem_strb = '0; imem_wdata = '0; imem_addr = '0; imem_ack = 0;
      dmem_req = 0; dmem_wen = 0; dmem_strb = '0; dmem_wdata = '0; dmem_addr = '0; dmem_ack = 0;
      mem_gnt = 0; mem_recv = 0; mem_error = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      @(negedge g_clk);
      clear_inputs();
      g_resetn = 0;
      @(negedge g_clk);
      g_resetn = 1;
   endtask

   task automatic cyc();
      @(negedge g_clk);
   endtask

   logic [3:0]  exp_pat;
   logic        own;

   initial begin
      clear_inputs();
      g_resetn = 0;
      repeat (2) cyc();
      #1;
      // reset state: all outputs 0
      check("rst_ports_i", {imem_gnt, imem_recv, imem_error}, 0);
      check("rst_ports_d", {dmem_gnt, dmem_recv, dmem_error}, 0);
      check("rst_mem_ctl", {mem_req, mem_wen, mem_ack, mem_strb}, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_rdata", imem_rdata | dmem_rdata, 0);
      check("rst_spur", err_spurious, 0);
      g_resetn = 1;

      // test 1: single dmem read
      cyc();
      dmem_req = 1; dmem_addr = 32'h8000_0010; mem_gnt = 1;
      #1;
      check("t1_dgnt", dmem_gnt, 1);
      check("t1_ignt", imem_gnt, 0);
      check("t1_req", mem_req, 1);
      check("t1_addr", mem_addr, 32'h8000_0010);
      cyc();
      dmem_req = 0; mem_gnt = 0; mem_recv = 1; mem_rdata = 32'hDEAD_BEEF; dmem_ack = 1;
      #1;
      check("t1_drecv", dmem_recv, 1);
      check("t1_irecv", imem_recv, 0);
      check("t1_drdata", dmem_rdata, 32'hDEAD_BEEF);
      check("t1_irdata", imem_rdata, 0);
      check("t1_ack", mem_ack, 1);
      cyc();
      clear_inputs();
      #1;
      check("t1_spur", err_spurious, 0);

      // test 2: both ports contend, responses drained as grants happen
`ifdef FRV_MEM_ARB_RR_EN
      exp_pat = 4'b0101;
`else
      exp_pat = 4'b1111;
`endif
      do_reset();
      for (int c = 0; c < 5; c++) begin
         cyc();
         imem_req = (c < 4); dmem_req = (c < 4); mem_gnt = (c < 4);
         imem_addr = 32'h0000_1000; dmem_addr = 32'h0000_2000;
         imem_ack = 1; dmem_ack = 1;
         mem_recv = (c > 0); mem_rdata = 32'h100 + c;
         #1;
         if (c < 4) begin
            check($sformatf("t2_dgnt%0d", c), dmem_gnt, exp_pat[c]);
            check($sformatf("t2_ignt%0d", c), imem_gnt, !exp_pat[c]);
            check($sformatf("t2_addr%0d", c), mem_addr, exp_pat[c] ? 32'h2000 : 32'h1000);
         end
         if (c > 0) begin
            own = exp_q.pop_front();
            check($sformatf("t2_drecv%0d", c), dmem_recv, own);
            check($sformatf("t2_irecv%0d", c), imem_recv, !own);
            check($sformatf("t2_rdata%0d", c), own ? dmem_rdata : imem_rdata, 32'h100 + c);
         end
         if (c < 4) exp_q.push_back(exp_pat[c]);
      end

      // test 3: stalled imem request keeps the bus while dmem arrives
      do_reset();
      cyc();
      imem_req = 1; imem_addr = 32'h0000_3000; imem_wen = 1; imem_strb = 4'b0011;
      imem_wdata = 32'h1234_5678;
      #1;
      check("t3_c1_addr", mem_addr, 32'h3000);
      check("t3_c1_ignt", imem_gnt, 0);
      cyc();
      dmem_req = 1; dmem_addr = 32'h0000_4000;
      #1;
      check("t3_c2_addr", mem_addr, 32'h3000);
      check("t3_c2_dgnt", dmem_gnt, 0);
      cyc();
      #1;
      check("t3_c3_addr", mem_addr, 32'h3000);
      cyc();
      mem_gnt = 1;
      #1;
      check("t3_c4_ignt", imem_gnt, 1);
      check("t3_c4_dgnt", dmem_gnt, 0);
      check("t3_c4_wr", {mem_wen, mem_strb}, 5'b1_0011);
      check("t3_c4_wdata", mem_wdata, 32'h1234_5678);
      cyc();
      imem_req = 0;
      #1;
      check("t3_c5_dgnt", dmem_gnt, 1);
      check("t3_c5_addr", mem_addr, 32'h4000);

      // test 4: FIFO full stalls requests; one pop re-opens the bus
      do_reset();
      cyc();
      imem_req = 1; mem_gnt = 1;
      #1;
      check("t4_g1", imem_gnt, 1);
      cyc();
      imem_req = 0; dmem_req = 1;
      #1;
      check("t4_g2", dmem_gnt, 1);
      cyc();
      dmem_req = 0; imem_req = 1;
      #1;
      check("t4_full_req", mem_req, 0);
      check("t4_full_gnt", imem_gnt, 0);
      cyc();
      mem_recv = 1; imem_ack = 1; mem_rdata = 32'h0000_0055;
      #1;
      check("t4_pop_req", mem_req, 0);
      check("t4_pop_recv", imem_recv, 1);
      check("t4_pop_ack", mem_ack, 1);
      cyc();
      mem_recv = 0;
      #1;
      check("t4_reopen_req", mem_req, 1);
      check("t4_reopen_gnt", imem_gnt, 1);

      // test 6 (after a mid-operation reset): late response is spurious
      do_reset();
      cyc();
      mem_recv = 1; mem_rdata = 32'hCAFE_0000;
      #1;
      check("t6_ack", mem_ack, 1);
      check("t6_recv", {imem_recv, dmem_recv}, 0);
      check("t6_rdata", imem_rdata | dmem_rdata, 0);
      check("t6_spur_pre", err_spurious, 0);
      cyc();
      mem_recv = 0;
      #1;
      check("t6_spur_set", err_spurious, 1);
      check("t6_ack_idle", mem_ack, 0);
      repeat (3) cyc();
      #1;
      check("t6_spur_hold", err_spurious, 1);
      g_resetn = 0;
      cyc();
      #1;
      check("t6_spur_clr", err_spurious, 0);
      g_resetn = 1;

      // test 5: head owner back-pressures its response
      do_reset();
      cyc();
      imem_req = 1; mem_gnt = 1;
      #1;
      check("t5_ig", imem_gnt, 1);
      cyc();
      imem_req = 0; dmem_req = 1;
      #1;
      check("t5_dg", dmem_gnt, 1);
      cyc();
      dmem_req = 0; mem_gnt = 0;
      mem_recv = 1; mem_rdata = 32'hAAAA_0001; imem_ack = 0; dmem_ack = 1;
      #1;
      check("t5_c1_irecv", imem_recv, 1);
      check("t5_c1_ack", mem_ack, 0);
      check("t5_c1_irdata", imem_rdata, 32'hAAAA_0001);
      check("t5_c1_drecv", dmem_recv, 0);
      cyc();
      #1;
      check("t5_c2_irecv", imem_recv, 1);
      check("t5_c2_ack", mem_ack, 0);
      cyc();
      imem_ack = 1;
      #1;
      check("t5_c3_irecv", imem_recv, 1);
      check("t5_c3_ack", mem_ack, 1);
      cyc();
      imem_ack = 0; mem_rdata = 32'hBBBB_0002; mem_error = 1;
      #1;
      check("t5_c4_drecv", dmem_recv, 1);
      check("t5_c4_irecv", imem_recv, 0);
      check("t5_c4_drdata", dmem_rdata, 32'hBBBB_0002);
      check("t5_c4_irdata", imem_rdata, 0);
      check("t5_c4_err", {imem_error, dmem_error}, 2'b01);
      check("t5_c4_ack", mem_ack, 1);
      cyc();
      clear_inputs();
      #1;
      check("t5_spur", err_spurious, 0);

      // final report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
